// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/decode/execute sequencer with a small ALU,
// driving a 3-register file (A, B, ACC) that reads on posedge, writes on negedge.
// Optional build macro: TRAP_ILLEGAL_EN (opcodes 8-15 halt instead of acting as NOP).
module exec_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic              InstrReq,
    output logic [ADDR_W-1:0] PC,
    input  logic              InstrValid,
    input  logic [31:0]       Instr,
    output logic [1:0]        Fonte1,
    output logic [1:0]        Fonte2,
    input  logic [31:0]       Dado1,
    input  logic [31:0]       Dado2,
    output logic              Esc,
    output logic [1:0]        RegEsc,
    output logic [31:0]       Dado,
    output logic              Halted
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_OPERAND = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_LDI  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    logic [2:0]  state;
    logic [31:0] ir;
    logic [31:0] res;

    logic [3:0]  op;
    logic [1:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic        unused_ir;

    assign op        = ir[31:28];
    assign rd        = ir[27:26];
    assign rs1       = ir[25:24];
    assign rs2       = ir[23:22];
    assign imm       = ir[15:0];
    assign unused_ir = ^ir[21:16];

    // ALU: operands are the RF read data valid during EXEC
    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = Dado1 + Dado2;
            OP_SUB:  res = Dado1 - Dado2;
            OP_AND:  res = Dado1 & Dado2;
            OP_OR:   res = Dado1 | Dado2;
            OP_LDI:  res = {{16{imm[15]}}, imm};
            OP_MOV:  res = Dado1;
            default: res = '0;
        endcase
    end

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_FETCH;
            PC       <= RESET_PC;
            ir       <= '0;
            Fonte1   <= 2'b00;
            Fonte2   <= 2'b00;
            RegEsc   <= 2'b00;
            Esc      <= 1'b0;
            Dado     <= '0;
            InstrReq <= 1'b0;
            Halted   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // accept only while the request is visible to the memory
                    if (InstrReq && InstrValid) begin
                        ir       <= Instr;
                        InstrReq <= 1'b0;
                        state    <= S_DECODE;
                    end else begin
                        InstrReq <= 1'b1;
                    end
                end
                S_DECODE: begin
                    // selects go out now so the RF read lands during EXEC
                    Fonte1 <= rs1;
                    Fonte2 <= rs2;
                    if (op == OP_HALT) begin
                        Halted <= 1'b1;
                        state  <= S_HALT;
                    end
`ifdef TRAP_ILLEGAL_EN
                    else if (op[3]) begin
                        // PC is left at the offending address
                        Halted <= 1'b1;
                        state  <= S_HALT;
                    end
`endif
                    else if (op == OP_NOP || op[3]) begin
                        PC       <= PC + ADDR_W'(1);
                        InstrReq <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_OPERAND;
                    end
                end
                S_OPERAND: state <= S_EXEC;
                S_EXEC: begin
                    Dado   <= res;
                    RegEsc <= rd;
                    Esc    <= 1'b1;
                    state  <= S_WB;
                end
                S_WB: begin
                    // RF wrote at the negedge inside this cycle
                    Esc      <= 1'b0;
                    PC       <= PC + ADDR_W'(1);
                    InstrReq <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    InstrReq <= 1'b0;
                    Esc      <= 1'b0;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: models the 3-register file and an instruction source,
// runs a table of single instructions, then hand sequences for wrap, reset, trap, halt.
module tb_exec_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        InstrReq;
    logic [7:0]  PC;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [1:0]  Fonte1, Fonte2;
    logic [31:0] Dado1, Dado2;
    logic        Esc;
    logic [1:0]  RegEsc;
    logic [31:0] Dado;
    logic        Halted;

    int n_run  = 0;
    int n_fail = 0;

    exec_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InstrReq(InstrReq), .PC(PC),
        .InstrValid(InstrValid), .Instr(Instr),
        .Fonte1(Fonte1), .Fonte2(Fonte2), .Dado1(Dado1), .Dado2(Dado2),
        .Esc(Esc), .RegEsc(RegEsc), .Dado(Dado), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    // register file model: A=0, B=1, ACC=2; select 11 reads zero
    logic [31:0] rf [3];

    function automatic logic [31:0] rf_rd(input logic [1:0] s);
        return (s == 2'b11) ? 32'h0 : rf[s];
    endfunction

    always @(posedge Clk) begin
        Dado1 <= rf_rd(Fonte1);
        Dado2 <= rf_rd(Fonte2);
    end

    always @(negedge Clk) begin
        if (!Rst_n) rf <= '{default: 32'h0};
        else if (Esc) rf[RegEsc[1] ? 2'd2 : RegEsc] <= Dado;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // issue one instruction, optionally holding InstrValid low for 'stall' cycles;
    // returns cycles until the next request (or halt) and the Esc-high cycle count
    task automatic exec(input logic [31:0] ins, input int stall,
                        output int cyc, output int escn, output logic pc_ok);
        logic [7:0] pc0;
        int guard;
        cyc = 0; escn = 0; pc_ok = 1'b1; guard = 0;
        InstrValid = 1'b0;
        while (!InstrReq && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        check("fetch_ready", {31'h0, InstrReq}, 32'h1);
        pc0   = PC;
        Instr = ins;
        for (int i = 0; i < stall; i++) begin
            @(negedge Clk);
            cyc++;
            if (!InstrReq || PC != pc0) pc_ok = 1'b0;
        end
        InstrValid = 1'b1;
        @(negedge Clk);
        cyc++;
        InstrValid = 1'b0;
        if (Esc) escn++;
        while (!InstrReq && !Halted && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (Esc) escn++;
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          stall;
        int          cyc;
        logic [31:0] a, b, acc;
    } vec_t;

    vec_t vt [13];

    initial begin
        int         cyc, escn;
        logic       pc_ok;
        logic [7:0] pc_before;
        int         guard;

        vt[0]  = '{"ldi_a_ffff", 32'h5000FFFF, 0, 5, 32'hFFFFFFFF, 32'h0,      32'h0};
        vt[1]  = '{"ldi_b_3",    32'h54000003, 0, 5, 32'hFFFFFFFF, 32'h3,      32'h0};
        vt[2]  = '{"add_wrap",   32'h18400000, 0, 5, 32'hFFFFFFFF, 32'h3,      32'h2};
        vt[3]  = '{"ldi_a_0",    32'h50000000, 0, 5, 32'h0,        32'h3,      32'h2};
        vt[4]  = '{"ldi_b_1",    32'h54000001, 0, 5, 32'h0,        32'h1,      32'h2};
        vt[5]  = '{"sub_wrap",   32'h28400000, 0, 5, 32'h0,        32'h1,      32'hFFFFFFFF};
        vt[6]  = '{"ldi_sext",   32'h50008000, 0, 5, 32'hFFFF8000, 32'h1,      32'hFFFFFFFF};
        vt[7]  = '{"mov_zero",   32'h63000000, 0, 5, 32'h0,        32'h1,      32'hFFFFFFFF};
        vt[8]  = '{"ldi_a_1234", 32'h50001234, 0, 5, 32'h1234,     32'h1,      32'hFFFFFFFF};
        vt[9]  = '{"and_acc",    32'h34800000, 0, 5, 32'h1234,     32'h1234,   32'hFFFFFFFF};
        vt[10] = '{"or_rd11",    32'h4CC00000, 0, 5, 32'h1234,     32'h1234,   32'h1234};
        vt[11] = '{"mov_stall",  32'h67000000, 3, 8, 32'h1234,     32'h0,      32'h1234};
        vt[12] = '{"nop",        32'h00000000, 0, 2, 32'h1234,     32'h0,      32'h1234};

        Rst_n = 1'b0; InstrValid = 1'b0; Instr = 32'h0;
        repeat (2) @(negedge Clk);
        check("rst_instrreq", {31'h0, InstrReq}, 32'h0);
        check("rst_pc",       {24'h0, PC},       32'h0);
        check("rst_esc",      {31'h0, Esc},      32'h0);
        check("rst_halted",   {31'h0, Halted},   32'h0);
        check("rst_dado",     Dado,              32'h0);
        check("rst_sel",      {26'h0, Fonte1, Fonte2, RegEsc}, 32'h0);
        Rst_n = 1'b1;

        foreach (vt[i]) begin
            pc_before = PC;
            exec(vt[i].ins, vt[i].stall, cyc, escn, pc_ok);
            check({vt[i].name, "_cyc"}, cyc, vt[i].cyc);
            check({vt[i].name, "_esc"}, escn, (vt[i].ins[31:28] == 4'h0) ? 0 : 1);
            check({vt[i].name, "_pc"},  {24'h0, PC}, {24'h0, pc_before + 8'd1});
            check({vt[i].name, "_a"},   rf[0], vt[i].a);
            check({vt[i].name, "_b"},   rf[1], vt[i].b);
            check({vt[i].name, "_acc"}, rf[2], vt[i].acc);
            if (vt[i].stall > 0) check({vt[i].name, "_hold"}, {31'h0, pc_ok}, 32'h1);
        end

        // PC wrap on a NOP at the top address
        guard = 0;
        while (PC != 8'hFF && guard < 300) begin
            exec(32'h0, 0, cyc, escn, pc_ok);
            guard++;
        end
        check("wrap_pre_pc", {24'h0, PC}, 32'hFF);
        exec(32'h0, 0, cyc, escn, pc_ok);
        check("wrap_cyc", cyc, 2);
        check("wrap_esc", escn, 0);
        check("wrap_pc",  {24'h0, PC}, 32'h0);

        // reset asserted while Esc is high in WB
        exec(32'h0, 0, cyc, escn, pc_ok);
        Instr = 32'h5000ABCD; InstrValid = 1'b1;
        @(negedge Clk);
        InstrValid = 1'b0;
        guard = 0;
        while (!Esc && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        check("wb_reached", {31'h0, Esc}, 32'h1);
        check("wb_pc",      {24'h0, PC},  32'h1);
        #2 Rst_n = 1'b0;
        #1;
        check("rstwb_esc", {31'h0, Esc},      32'h0);
        check("rstwb_pc",  {24'h0, PC},       32'h0);
        check("rstwb_req", {31'h0, InstrReq}, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rstwb_fetch", {31'h0, InstrReq}, 32'h1);

        // illegal opcode 0xA
        exec(32'hA0000000, 0, cyc, escn, pc_ok);
        check("ill_cyc", cyc, 2);
        check("ill_esc", escn, 0);
`ifdef TRAP_ILLEGAL_EN
        check("ill_halted", {31'h0, Halted},   32'h1);
        check("ill_pc",     {24'h0, PC},       32'h0);
        check("ill_req",    {31'h0, InstrReq}, 32'h0);
`else
        check("ill_halted", {31'h0, Halted},   32'h0);
        check("ill_pc",     {24'h0, PC},       32'h1);
        check("ill_req",    {31'h0, InstrReq}, 32'h1);
`endif

        // HALT is sticky: no requests, no writes, PC frozen
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        exec(32'h00000000, 0, cyc, escn, pc_ok);
        exec(32'h70000000, 0, cyc, escn, pc_ok);
        check("halt_cyc",    cyc, 2);
        check("halt_halted", {31'h0, Halted}, 32'h1);
        check("halt_pc",     {24'h0, PC},     32'h1);
        Instr = 32'h5000FFFF; InstrValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("halt_sticky", {29'h0, Halted, InstrReq, Esc}, 32'h4);
            check("halt_pc_frz", {24'h0, PC}, 32'h1);
        end
        InstrValid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
